// File: rtl/keypad_entry_buffer.sv
// Debounces the scanner's held key code and turns each accepted press into one
// digit push, backspace or enter; completed entries leave over valid/ready.
//
// state      | meaning
// S_IDLE     | no key held, waiting for a non-none code
// S_DEBOUNCE | candidate code seen, counting consecutive matching samples
// S_PRESSED  | press accepted and acted on, waiting for the key to go away
// S_RELEASE  | key gone, counting consecutive none samples before re-arming
module keypad_entry_buffer #(
    parameter  int DIGITS     = 4,
    parameter  int STABLE_CYC = 8000,
    localparam int CW         = $clog2(DIGITS + 1),
    localparam int DW         = 4 * DIGITS
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [3:0]    key_code,
    output logic [DW-1:0] digits,
    output logic [CW-1:0] digit_cnt,
    output logic          key_event,
    output logic [3:0]    key_value,
    output logic          err,
    output logic          commit_valid,
    output logic [DW-1:0] commit_data,
    output logic [CW-1:0] commit_len,
    input  logic          commit_ready
);

    localparam int            SW        = $clog2(STABLE_CYC + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DIGITS);
    localparam logic [DW-1:0] BLANK     = {DIGITS{4'hF}};

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] stab_cnt, stab_nxt;
    logic [3:0]    cand, cand_nxt;
    logic          fire;

    logic [DW-1:0] digits_nxt, cdata_nxt;
    logic [CW-1:0] cnt_nxt, clen_nxt;
    logic          kev_nxt, err_nxt, cvalid_nxt;
    logic [3:0]    kval_nxt, dval;

    logic key_none, at_last;

    assign key_none = (key_code == 4'hF) || (key_code == 4'h0) ||
                      (key_code == 4'hD) || (key_code == 4'hE);
    assign at_last  = (stab_cnt == STAB_LAST);
    assign dval     = (cand == 4'hB) ? 4'h0 : cand;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= S_IDLE;
            stab_cnt     <= '0;
            cand         <= 4'hF;
            digits       <= BLANK;
            digit_cnt    <= '0;
            key_event    <= 1'b0;
            key_value    <= 4'hF;
            err          <= 1'b0;
            commit_valid <= 1'b0;
            commit_data  <= BLANK;
            commit_len   <= '0;
        end else begin
            state        <= state_nxt;
            stab_cnt     <= stab_nxt;
            cand         <= cand_nxt;
            digits       <= digits_nxt;
            digit_cnt    <= cnt_nxt;
            key_event    <= kev_nxt;
            key_value    <= kval_nxt;
            err          <= err_nxt;
            commit_valid <= cvalid_nxt;
            commit_data  <= cdata_nxt;
            commit_len   <= clen_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        cand_nxt  = cand;
        fire      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!key_none) begin
                    cand_nxt  = key_code;
                    stab_nxt  = SW'(1);
                    state_nxt = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (key_none) begin
                    state_nxt = S_IDLE;
                end else if (key_code == cand) begin
                    if (at_last) begin
                        fire      = 1'b1;
                        state_nxt = S_PRESSED;
                    end else begin
                        stab_nxt = stab_cnt + SW'(1);
                    end
                end else begin
                    cand_nxt = key_code;
                    stab_nxt = SW'(1);
                end
            end
            S_PRESSED: begin
                if (key_none) begin
                    stab_nxt  = SW'(1);
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!key_none) begin
                    state_nxt = S_PRESSED;
                end else if (at_last) begin
                    state_nxt = S_IDLE;
                end else begin
                    stab_nxt = stab_cnt + SW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Action datapath: evaluated only on the edge the press is accepted.
    always_comb begin
        digits_nxt = digits;
        cnt_nxt    = digit_cnt;
        cdata_nxt  = commit_data;
        clen_nxt   = commit_len;
        cvalid_nxt = commit_valid && !commit_ready;
        kev_nxt    = fire;
        kval_nxt   = fire ? cand : key_value;
        err_nxt    = 1'b0;
        if (fire) begin
            if (commit_valid) begin
                err_nxt = 1'b1;
            end else if (cand == 4'hA) begin
                if (digit_cnt != '0) begin
                    digits_nxt = DW'({4'hF, digits} >> 4);
                    cnt_nxt    = digit_cnt - CW'(1);
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (cand == 4'hC) begin
                if (digit_cnt != '0) begin
                    cdata_nxt  = digits;
                    clen_nxt   = digit_cnt;
                    cvalid_nxt = 1'b1;
                    digits_nxt = BLANK;
                    cnt_nxt    = '0;
                end else begin
                    err_nxt = 1'b1;
                end
            end else begin
                if (digit_cnt < CNT_FULL) begin
                    digits_nxt = DW'({digits, dval});
                    cnt_nxt    = digit_cnt + CW'(1);
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end
    end

endmodule
